// File: rtl/dmem_host_arbiter_if.sv
// Bus bundle between the ME stage, the host register block, data memory and the arbiter.
// slave is the arbiter view; master is the surrounding environment view.
interface dmem_host_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
);
   logic              host_req;
   logic              host_rw;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_busy;
   logic              host_done;
   logic [DATA_W-1:0] host_rdata;
   logic              cpu_run;
   logic              cpu_wea;
   logic              cpu_rea;
   logic [DATA_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic              mem_wea;
   logic              mem_rea;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  host_req, host_rw, host_addr, host_wdata,
      input  cpu_run, cpu_wea, cpu_rea, cpu_addr, cpu_wdata,
      input  mem_rdata,
      output host_busy, host_done, host_rdata,
      output cpu_rdata, cpu_stall,
      output mem_wea, mem_rea, mem_addr, mem_wdata
   );

   modport master (
      output host_req, host_rw, host_addr, host_wdata,
      output cpu_run, cpu_wea, cpu_rea, cpu_addr, cpu_wdata,
      output mem_rdata,
      input  host_busy, host_done, host_rdata,
      input  cpu_rdata, cpu_stall,
      input  mem_wea, mem_rea, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_host_arbiter.sv
// Shares the single-port data memory between the ME stage and the host register interface.
// Host accesses use idle ME cycles; after MAX_WAIT busy cycles the pipeline is frozen for one cycle.
module dmem_host_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 64,
   parameter int MAX_WAIT = 16
) (
   input logic                clk,
   input logic                rst,
   dmem_host_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   state_t            state_r;
   logic [CNT_W-1:0]  wait_cnt_r;
   logic              req_q_r;
   logic              rw_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              done_r;
   logic [DATA_W-1:0] rdata_r;

   logic              cpu_use_s;
   logic              req_edge_s;
   logic              host_grant_s;
   logic              mem_wea_s;
   logic              mem_rea_s;
   logic [DATA_W-1:0] mem_addr_s;
   logic [DATA_W-1:0] mem_wdata_s;

   // Port ownership: the host takes the bus in STALL, or in WAIT when the CPU leaves it idle.
   always_comb begin
      cpu_use_s    = bus.cpu_run & (bus.cpu_wea | bus.cpu_rea);
      req_edge_s   = bus.host_req & ~req_q_r;
      host_grant_s = (state_r == ST_STALL) | ((state_r == ST_WAIT) & ~cpu_use_s);
      if (host_grant_s) begin
         mem_wea_s   = ~rw_r;
         mem_rea_s   = rw_r;
         mem_addr_s  = {{(DATA_W-ADDR_W-2){1'b0}}, addr_r, 2'b00};
         mem_wdata_s = wdata_r;
      end else begin
         mem_wea_s   = bus.cpu_wea & bus.cpu_run;
         mem_rea_s   = bus.cpu_rea & bus.cpu_run;
         mem_addr_s  = bus.cpu_addr;
         mem_wdata_s = bus.cpu_wdata;
      end
   end

   // Arbiter FSM with host request capture, wait counter and host result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= '0;
         req_q_r    <= 1'b0;
         rw_r       <= 1'b0;
         addr_r     <= '0;
         wdata_r    <= '0;
         done_r     <= 1'b0;
         rdata_r    <= '0;
      end else begin
         req_q_r <= bus.host_req;
         case (state_r)
            ST_IDLE: begin
               if (req_edge_s) begin
                  rw_r       <= bus.host_rw;
                  addr_r     <= bus.host_addr;
                  wdata_r    <= bus.host_wdata;
                  done_r     <= 1'b0;
                  wait_cnt_r <= '0;
                  state_r    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!cpu_use_s) begin
                  if (rw_r) begin
                     rdata_r <= bus.mem_rdata;
                  end
                  done_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end else if (wait_cnt_r == WAIT_LAST) begin
                  state_r <= ST_STALL;
               end else begin
                  wait_cnt_r <= wait_cnt_r + CNT_W'(1);
               end
            end
            ST_STALL: begin
               if (rw_r) begin
                  rdata_r <= bus.mem_rdata;
               end
               done_r  <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.host_busy  = (state_r != ST_IDLE);
   assign bus.host_done  = done_r;
   assign bus.host_rdata = rdata_r;
   assign bus.cpu_stall  = (state_r == ST_STALL);
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.mem_wea    = mem_wea_s;
   assign bus.mem_rea    = mem_rea_s;
   assign bus.mem_addr   = mem_addr_s;
   assign bus.mem_wdata  = mem_wdata_s;
endmodule

// File: tb/tb_dmem_host_arbiter.sv
// Directed bench for dmem_host_arbiter with a behavioural single-port memory behind the bus.
module tb_dmem_host_arbiter;
   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 64;
   localparam int MAX_WAIT = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   errors  = 0;
   int   writes  = 0;
   int   wr_before;

   logic [63:0] mem_model [0:1023] = '{default: 64'd0};

   dmem_host_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dmem_host_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on the rising edge, counts every write.
   assign bus.mem_rdata = mem_model[bus.mem_addr[11:2]];
   always @(posedge clk) begin
      if (bus.mem_wea) begin
         mem_model[bus.mem_addr[11:2]] <= bus.mem_wdata;
         writes <= writes + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      bus.host_req   = 1'b0;
      bus.host_rw    = 1'b0;
      bus.host_addr  = 8'h00;
      bus.host_wdata = 64'h0;
      bus.cpu_run    = 1'b0;
      bus.cpu_wea    = 1'b0;
      bus.cpu_rea    = 1'b0;
      bus.cpu_addr   = 64'h0;
      bus.cpu_wdata  = 64'h0;

      // Reset state
      adv(); adv();
      mid();
      chk("rst_busy",  {63'd0, bus.host_busy}, 64'd0);
      chk("rst_done",  {63'd0, bus.host_done}, 64'd0);
      chk("rst_rdata", bus.host_rdata, 64'd0);
      chk("rst_stall", {63'd0, bus.cpu_stall}, 64'd0);
      chk("rst_wea",   {63'd0, bus.mem_wea}, 64'd0);
      adv();
      rst = 1'b1;
      adv();

      // 1: host write with CPU idle
      bus.host_req = 1'b1; bus.host_rw = 1'b0; bus.host_addr = 8'h05;
      bus.host_wdata = 64'hDEADBEEF_01234567;
      adv(); mid();
      chk("t1_busy",  {63'd0, bus.host_busy}, 64'd1);
      chk("t1_wea",   {63'd0, bus.mem_wea}, 64'd1);
      chk("t1_addr",  bus.mem_addr, 64'h14);
      chk("t1_wdata", bus.mem_wdata, 64'hDEADBEEF_01234567);
      chk("t1_stall", {63'd0, bus.cpu_stall}, 64'd0);
      adv(); mid();
      chk("t1_done",  {63'd0, bus.host_done}, 64'd1);
      chk("t1_idle",  {63'd0, bus.host_busy}, 64'd0);
      chk("t1_stall2", {63'd0, bus.cpu_stall}, 64'd0);
      bus.host_req = 1'b0;
      adv();

      // 2: host read back, one busy cycle
      bus.host_req = 1'b1; bus.host_rw = 1'b1; bus.host_addr = 8'h05;
      adv(); mid();
      chk("t2_busy",  {63'd0, bus.host_busy}, 64'd1);
      chk("t2_done0", {63'd0, bus.host_done}, 64'd0);
      chk("t2_rea",   {63'd0, bus.mem_rea}, 64'd1);
      chk("t2_wea",   {63'd0, bus.mem_wea}, 64'd0);
      adv(); mid();
      chk("t2_idle",  {63'd0, bus.host_busy}, 64'd0);
      chk("t2_done",  {63'd0, bus.host_done}, 64'd1);
      chk("t2_rdata", bus.host_rdata, 64'hDEADBEEF_01234567);
      bus.host_req = 1'b0;
      adv();

      // 3: CPU holds the port, host read forces a single stall cycle
      bus.cpu_run = 1'b1; bus.cpu_rea = 1'b1; bus.cpu_addr = 64'h100;
      bus.host_req = 1'b1; bus.host_rw = 1'b1; bus.host_addr = 8'h05;
      adv();
      for (int i = 0; i < MAX_WAIT; i++) begin
         mid();
         chk("t3_wbusy",  {63'd0, bus.host_busy}, 64'd1);
         chk("t3_wstall", {63'd0, bus.cpu_stall}, 64'd0);
         chk("t3_waddr",  bus.mem_addr, 64'h100);
         adv();
      end
      mid();
      chk("t3_stall", {63'd0, bus.cpu_stall}, 64'd1);
      chk("t3_sbusy", {63'd0, bus.host_busy}, 64'd1);
      chk("t3_saddr", bus.mem_addr, 64'h14);
      adv(); mid();
      chk("t3_stall_end", {63'd0, bus.cpu_stall}, 64'd0);
      chk("t3_done",  {63'd0, bus.host_done}, 64'd1);
      chk("t3_idle",  {63'd0, bus.host_busy}, 64'd0);
      chk("t3_rdata", bus.host_rdata, 64'hDEADBEEF_01234567);
      chk("t3_resume", bus.mem_addr, 64'h100);
      bus.cpu_rea = 1'b0; bus.host_req = 1'b0;
      adv();

      // 4: CPU stores for 3 WAIT cycles, host write granted on the 4th
      bus.host_req = 1'b1; bus.host_rw = 1'b0; bus.host_addr = 8'h0A;
      bus.host_wdata = 64'h5555_AAAA_5555_AAAA;
      bus.cpu_wea = 1'b1; bus.cpu_addr = 64'h200; bus.cpu_wdata = 64'hA0A0_A0A0_A0A0_A0A0;
      adv(); mid();
      chk("t4_w1addr", bus.mem_addr, 64'h200);
      chk("t4_w1done", {63'd0, bus.host_done}, 64'd0);
      adv(); mid();
      chk("t4_w2addr", bus.mem_addr, 64'h200);
      adv();
      bus.cpu_addr = 64'h300; bus.cpu_wdata = 64'h0000_0000_00C0_FFEE;
      mid();
      chk("t4_w3addr",  bus.mem_addr, 64'h300);
      chk("t4_w3wdata", bus.mem_wdata, 64'h0000_0000_00C0_FFEE);
      adv();
      bus.cpu_wea = 1'b0;
      mid();
      chk("t4_gaddr",  bus.mem_addr, 64'h28);
      chk("t4_gwea",   {63'd0, bus.mem_wea}, 64'd1);
      chk("t4_gstall", {63'd0, bus.cpu_stall}, 64'd0);
      adv(); mid();
      chk("t4_done",   {63'd0, bus.host_done}, 64'd1);
      chk("t4_cpumem", mem_model[10'h0C0], 64'h0000_0000_00C0_FFEE);
      chk("t4_hostmem", mem_model[10'h00A], 64'h5555_AAAA_5555_AAAA);
      bus.host_req = 1'b0;
      adv();

      // 5: halted CPU never drives writes; host read granted immediately
      bus.cpu_run = 1'b0; bus.cpu_wea = 1'b1; bus.cpu_addr = 64'h40;
      mid();
      chk("t5_wea_idle", {63'd0, bus.mem_wea}, 64'd0);
      adv();
      bus.host_req = 1'b1; bus.host_rw = 1'b1; bus.host_addr = 8'h0A;
      adv(); mid();
      chk("t5_rea",  {63'd0, bus.mem_rea}, 64'd1);
      chk("t5_wea",  {63'd0, bus.mem_wea}, 64'd0);
      chk("t5_addr", bus.mem_addr, 64'h28);
      adv(); mid();
      chk("t5_done",  {63'd0, bus.host_done}, 64'd1);
      chk("t5_rdata", bus.host_rdata, 64'h5555_AAAA_5555_AAAA);
      bus.host_req = 1'b0; bus.cpu_wea = 1'b0;
      adv();

      // 7: top word index maps without carry
      bus.host_req = 1'b1; bus.host_rw = 1'b0; bus.host_addr = 8'hFF;
      bus.host_wdata = 64'h1234_5678_9ABC_DEF0;
      adv(); mid();
      chk("t7_addr", bus.mem_addr, 64'h3FC);
      adv();
      bus.host_req = 1'b0;
      adv();

      // 6a: second req edge while busy is ignored
      bus.cpu_run = 1'b1; bus.cpu_rea = 1'b1; bus.cpu_addr = 64'h100;
      bus.host_req = 1'b1; bus.host_rw = 1'b0; bus.host_addr = 8'h20;
      bus.host_wdata = 64'h1111_1111_1111_1111;
      adv();
      bus.host_req = 1'b0;
      adv();
      bus.host_req = 1'b1; bus.host_addr = 8'h21; bus.host_wdata = 64'h2222_2222_2222_2222;
      adv();
      bus.cpu_rea = 1'b0;
      mid();
      chk("t6_gaddr",  bus.mem_addr, 64'h80);
      chk("t6_gwdata", bus.mem_wdata, 64'h1111_1111_1111_1111);
      adv(); mid();
      chk("t6_done", {63'd0, bus.host_done}, 64'd1);
      adv(); mid();
      chk("t6_noqueue", {63'd0, bus.host_busy}, 64'd0);
      chk("t6_nomem21", mem_model[10'h021], 64'd0);
      bus.host_req = 1'b0;
      adv();

      // 6b: reset during WAIT aborts the access without a write
      bus.cpu_rea = 1'b1;
      bus.host_req = 1'b1; bus.host_rw = 1'b0; bus.host_addr = 8'h33;
      bus.host_wdata = 64'h3333_3333_3333_3333;
      adv(); mid();
      chk("t6_wbusy", {63'd0, bus.host_busy}, 64'd1);
      wr_before = writes;
      rst = 1'b0;
      #1;
      chk("t6_rbusy",  {63'd0, bus.host_busy}, 64'd0);
      chk("t6_rdone",  {63'd0, bus.host_done}, 64'd0);
      chk("t6_rstall", {63'd0, bus.cpu_stall}, 64'd0);
      chk("t6_rwea",   {63'd0, bus.mem_wea}, 64'd0);
      bus.host_req = 1'b0;
      adv(); adv();
      rst = 1'b1;
      bus.cpu_rea = 1'b0; bus.cpu_run = 1'b0;
      adv(); mid();
      chk("t6_nowrite", 64'(writes), 64'(wr_before));
      chk("t6_nomem33", mem_model[10'h033], 64'd0);
      chk("t6_idle",    {63'd0, bus.host_busy}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
